// File: rtl/plab5_mcore_proc_resp_sec_buf.sv
// plab5_mcore_proc_resp_sec_buf
//
// Security-tagged response buffer between the network response port and the
// processor response access-control stage. Every accepted response is stored
// together with the 1-bit security level of its source. The head entry's
// message and level are presented from registered state, so the level seen
// by access control never comes live from the network (unless the bypass
// build option is compiled in).
//
// Optional feature macro: PLAB5_PROC_RESP_SEC_BUF_BYPASS_EN
//   defined   : an empty buffer forwards net_resp_* to acc_resp_*
//               combinationally; if acc_resp_rdy is also high, the response
//               passes straight through without being written.
//   undefined : no combinational path from net_resp_* to acc_resp_*.
//
// Handshake: a transfer on a port happens in a cycle where both val and rdy
// are high at the rising clock edge. val, once high, is held with stable
// payload until the transfer happens (or reset asserts). net_resp_rdy depends
// only on registered occupancy.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-low reset
//   net_resp_*    val/rdy/msg/sec from the network
//   acc_resp_*    val/rdy/msg/sec toward access control (head entry)
//   num_free      number of free entries, 0..p_num_entries

module plab5_mcore_proc_resp_sec_buf #(
  parameter  int p_opaque_nbits = 8,
  parameter  int p_addr_nbits   = 32,
  parameter  int p_data_nbits   = 32,
  parameter  int p_num_entries  = 2,
  // Mem response message: type(3) + opaque + test(2) + len + data
  localparam int resp_nbits     = 3 + p_opaque_nbits + 2
                                  + $clog2(p_data_nbits / 8) + p_data_nbits,
  localparam int ptr_nbits      = $clog2(p_num_entries),
  localparam int cnt_nbits      = $clog2(p_num_entries) + 1
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  net_resp_val,
  output logic                  net_resp_rdy,
  input  logic [resp_nbits-1:0] net_resp_msg,
  input  logic                  net_resp_sec,

  output logic                  acc_resp_val,
  input  logic                  acc_resp_rdy,
  output logic [resp_nbits-1:0] acc_resp_msg,
  output logic                  acc_resp_sec,

  output logic [cnt_nbits-1:0]  num_free
);

  // Address width is carried only for uniformity with the other mem ports;
  // it takes part in the configuration sanity check below.
  if (p_num_entries < 2 || (p_num_entries & (p_num_entries - 1)) != 0
      || p_addr_nbits < 1) begin : g_bad_cfg
    $error("plab5_mcore_proc_resp_sec_buf: bad parameter configuration");
  end

  localparam logic [cnt_nbits-1:0] full_count = cnt_nbits'(p_num_entries);

  logic [resp_nbits-1:0] msg_q [p_num_entries];
  logic                  sec_q [p_num_entries];

  logic [ptr_nbits-1:0]  enq_ptr_q, enq_ptr_d;
  logic [ptr_nbits-1:0]  deq_ptr_q, deq_ptr_d;
  logic [cnt_nbits-1:0]  count_q,   count_d;

  logic empty;
  logic enq_fire;   // network handshake completes
  logic deq_fire;   // access-control handshake completes
  logic bypass;     // response passes through an empty buffer unstored
  logic do_write;   // store into the array
  logic do_pop;     // retire a stored entry

  assign empty        = (count_q == '0);
  assign net_resp_rdy = (count_q != full_count);
  assign num_free     = full_count - count_q;

  // Head presentation. With bypass compiled in, an empty buffer shows the
  // network side directly; otherwise an empty buffer drives zeros rather
  // than stale array contents.
  always_comb begin
    bypass       = 1'b0;
    acc_resp_val = !empty;
    acc_resp_msg = '0;
    acc_resp_sec = 1'b0;
    if (!empty) begin
      acc_resp_msg = msg_q[deq_ptr_q];
      acc_resp_sec = sec_q[deq_ptr_q];
    end
`ifdef PLAB5_PROC_RESP_SEC_BUF_BYPASS_EN
    else begin
      acc_resp_val = net_resp_val;
      acc_resp_msg = net_resp_msg;
      acc_resp_sec = net_resp_sec;
      bypass       = net_resp_val && acc_resp_rdy;
    end
`endif
  end

  assign enq_fire = net_resp_val && net_resp_rdy;
  assign deq_fire = acc_resp_val && acc_resp_rdy;
  assign do_write = enq_fire && !bypass;
  // A bypassed transfer satisfies deq_fire but never touched the array.
  assign do_pop   = deq_fire && !empty;

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (do_write) enq_ptr_d = enq_ptr_q + 1'b1;  // power-of-two depth wraps
    if (do_pop)   deq_ptr_d = deq_ptr_q + 1'b1;
    if (do_write && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_write && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is not reset: an entry is only observable once count covers it.
  always_ff @(posedge clk) begin
    if (do_write) begin
      msg_q[enq_ptr_q] <= net_resp_msg;
      sec_q[enq_ptr_q] <= net_resp_sec;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_proc_resp_sec_buf.sv
module tb_plab5_mcore_proc_resp_sec_buf;

  // Message width re-derived: type 3 + opaque 8 + test 2 + len 2 + data 32
  localparam int RW = 47;
  localparam int CW = 2;

`ifdef PLAB5_PROC_RESP_SEC_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          net_resp_val;
  logic          net_resp_rdy;
  logic [RW-1:0] net_resp_msg;
  logic          net_resp_sec;
  logic          acc_resp_val;
  logic          acc_resp_rdy;
  logic [RW-1:0] acc_resp_msg;
  logic          acc_resp_sec;
  logic [CW-1:0] num_free;

  plab5_mcore_proc_resp_sec_buf #(
    .p_opaque_nbits (8),
    .p_addr_nbits   (32),
    .p_data_nbits   (32),
    .p_num_entries  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .net_resp_val (net_resp_val),
    .net_resp_rdy (net_resp_rdy),
    .net_resp_msg (net_resp_msg),
    .net_resp_sec (net_resp_sec),
    .acc_resp_val (acc_resp_val),
    .acc_resp_rdy (acc_resp_rdy),
    .acc_resp_msg (acc_resp_msg),
    .acc_resp_sec (acc_resp_sec),
    .num_free     (num_free)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [RW:0] exp_q[$];   // {sec, msg}

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ev,
                               input logic es, input logic [RW-1:0] em,
                               input logic [CW-1:0] ef, input logic er);
    check({tag, " acc_val"},  64'(acc_resp_val), 64'(ev));
    check({tag, " acc_sec"},  64'(acc_resp_sec), 64'(es));
    check({tag, " acc_msg"},  64'(acc_resp_msg), 64'(em));
    check({tag, " num_free"}, 64'(num_free),     64'(ef));
    check({tag, " net_rdy"},  64'(net_resp_rdy), 64'(er));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    net_resp_val = 1'b0;
    net_resp_sec = 1'b0;
    net_resp_msg = '0;
    acc_resp_rdy = 1'b0;
  endtask

  // Hold inputs across one rising edge, then return to idle so the
  // following check sees registered state only.
  task automatic apply(input logic nv, input logic ns, input logic [RW-1:0] nm,
                       input logic ar);
    net_resp_val = nv;
    net_resp_sec = ns;
    net_resp_msg = nm;
    acc_resp_rdy = ar;
    @(posedge clk);
    #1 drive_idle();
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          nv;
    logic          ns;
    logic [RW-1:0] nm;
    logic          ar;
    logic          ev;
    logic          es;
    logic [RW-1:0] em;
    logic [CW-1:0] ef;
    logic          er;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // A=0x11/sec1, B=0x22/sec0, C=0x33/sec1, E=0x55/sec0
    //             nv  ns  nm      ar    ev  es  em      ef  er
    vecs[0] = '{1'b1,1'b1,RW'('h11),1'b0, 1'b1,1'b1,RW'('h11),2'd1,1'b1}; // enq A
    vecs[1] = '{1'b1,1'b0,RW'('h22),1'b0, 1'b1,1'b1,RW'('h11),2'd0,1'b0}; // enq B, full
    vecs[2] = '{1'b0,1'b0,RW'(0),   1'b0, 1'b1,1'b1,RW'('h11),2'd0,1'b0}; // hold
    vecs[3] = '{1'b1,1'b1,RW'('h33),1'b1, 1'b1,1'b0,RW'('h22),2'd1,1'b1}; // full: deq A only
    vecs[4] = '{1'b1,1'b1,RW'('h33),1'b0, 1'b1,1'b0,RW'('h22),2'd0,1'b0}; // C enters
    vecs[5] = '{1'b0,1'b0,RW'(0),   1'b1, 1'b1,1'b1,RW'('h33),2'd1,1'b1}; // deq B
    vecs[6] = '{1'b1,1'b0,RW'('h55),1'b1, 1'b1,1'b0,RW'('h55),2'd1,1'b1}; // deq C + enq E
    vecs[7] = '{1'b0,1'b0,RW'(0),   1'b1, 1'b0,1'b0,RW'(0),   2'd2,1'b1}; // deq E, empty
    vecs[8] = '{1'b0,1'b0,RW'(0),   1'b1, 1'b0,1'b0,RW'(0),   2'd2,1'b1}; // deq on empty
  end

  // ---------------- test sequence ----------------
  initial begin
    drive_idle();
    repeat (2) @(posedge clk);
    #1 check_outputs("in_reset", 1'b0, 1'b0, '0, 2'd2, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2 check_outputs("after_reset", 1'b0, 1'b0, '0, 2'd2, 1'b1);

    // Table-driven directed vectors
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].nv, vecs[i].ns, vecs[i].nm, vecs[i].ar);
      check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es,
                    vecs[i].em, vecs[i].ef, vecs[i].er);
    end

    // Eight back-to-back responses, alternating sec, sink always ready
    for (int i = 0; i < 9; i++) begin
      logic exp_v;
      if (i < 8) begin
        net_resp_val = 1'b1;
        net_resp_sec = 1'(i % 2);
        net_resp_msg = RW'(32'h100 + i);
        exp_q.push_back({net_resp_sec, net_resp_msg});
      end else begin
        net_resp_val = 1'b0;
        net_resp_sec = 1'b0;
        net_resp_msg = '0;
      end
      acc_resp_rdy = 1'b1;
      #1;
      exp_v = BYP ? (i < 8) : (i >= 1);
      check($sformatf("b2b%0d acc_val", i), 64'(acc_resp_val), 64'(exp_v));
      if (acc_resp_val && exp_q.size() > 0) begin
        logic [RW:0] e;
        e = exp_q.pop_front();
        check($sformatf("b2b%0d acc_msg", i), 64'(acc_resp_msg), 64'(e[RW-1:0]));
        check($sformatf("b2b%0d acc_sec", i), 64'(acc_resp_sec), 64'(e[RW]));
      end
      @(posedge clk);
      #1;
    end
    drive_idle();
    #1;
    check("b2b drained", 64'(exp_q.size()), 64'd0);
    check("b2b num_free", 64'(num_free), 64'd2);

    // Reset asserted with two entries buffered: clears without a clock edge
    apply(1'b1, 1'b1, RW'('h66), 1'b0);
    apply(1'b1, 1'b1, RW'('h67), 1'b0);
    check("prefill num_free", 64'(num_free), 64'd0);
    #2 reset = 1'b0;
    #1 check_outputs("async_reset", 1'b0, 1'b0, '0, 2'd2, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2 check_outputs("post_async_reset", 1'b0, 1'b0, '0, 2'd2, 1'b1);

    // Empty buffer, response arriving with sink ready
    net_resp_val = 1'b1;
    net_resp_sec = 1'b1;
    net_resp_msg = RW'('h77);
    acc_resp_rdy = 1'b1;
    #1;
    check("bypass same_cycle acc_val", 64'(acc_resp_val), 64'(BYP));
    check("bypass same_cycle acc_sec", 64'(acc_resp_sec), 64'(BYP));
    check("bypass same_cycle num_free", 64'(num_free), 64'd2);
    @(posedge clk);
    #1 drive_idle();
    #1;
    check("bypass next acc_val", 64'(acc_resp_val), 64'(!BYP));
    check("bypass next acc_sec", 64'(acc_resp_sec), 64'(!BYP));
    check("bypass next num_free", 64'(num_free), BYP ? 64'd2 : 64'd1);
    if (!BYP) begin
      check("bypass next acc_msg", 64'(acc_resp_msg), 64'h77);
      apply(1'b0, 1'b0, '0, 1'b1);
      check_outputs("final_drain", 1'b0, 1'b0, '0, 2'd2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_proc_resp_sec_buf.md
# plab5_mcore_proc_resp_sec_buf

Security-tagged response buffer between the network response port and the processor response access-control stage. Each response accepted from the network is stored with the 1-bit security level of its source. The buffer presents the head entry's message and level to the access-control stage, so the level is driven from registered state, not taken live from the network. Depth is parameterizable and the ports use a val/rdy handshake.

## Interface
Parameters:
- p_opaque_nbits, 8, mem message opaque field bits
- p_addr_nbits, 32, mem message address bits (carried for uniformity, unused)
- p_data_nbits, 32, mem message data bits
- p_num_entries, 2, buffer depth; power of two, ≥2
- resp_nbits, `VC_MEM_RESP_MSG_NBITS(o,d)`, local, not set externally

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears state immediately
- net_resp_val  in  1  network response valid
- net_resp_rdy  out  1  buffer can accept
- net_resp_msg  in  resp_nbits  network response message
- net_resp_sec  in  1  security level of the response source, sampled with the message
- acc_resp_val  out  1  head entry valid
- acc_resp_rdy  in  1  access-control stage accepts
- acc_resp_msg  out  resp_nbits  head message
- acc_resp_sec  out  1  head entry security level (feeds resp_sec_level of access control)
- num_free  out  $clog2(p_num_entries)+1  free entries, 0..p_num_entries

## Operation
- Circular buffer:
  - Storage: msg array and sec array, p_num_entries each.
  - Pointers: enq_ptr and deq_ptr, each $clog2(p_num_entries) bits. They wrap naturally from p_num_entries-1 to 0.
  - Count: count register, width $clog2(p_num_entries)+1.
- Enqueue fires when net_resp_val && net_resp_rdy. On fire, msg and sec are written at enq_ptr and enq_ptr increments.
- Dequeue fires when acc_resp_val && acc_resp_rdy. On fire, deq_ptr increments.
- count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on both, or on neither.
- net_resp_rdy = (count != p_num_entries). It depends only on registered count; there is no combinational path from acc_resp_rdy.
- acc_resp_val = (count != 0). acc_resp_msg and acc_resp_sec are read from the deq_ptr entry.
- When count == 0, acc_resp_sec = 0 and acc_resp_msg = 0 (forced, not stale).
- num_free = p_num_entries - count.
- Boundary conditions:
  - Full: net_resp_rdy=0. A same-cycle dequeue does not admit an enqueue in that cycle.
  - Empty: acc_resp_val=0. An enqueue and dequeue request in the same cycle is only an enqueue, unless bypass is compiled in (see Configuration).
  - Simultaneous enqueue and dequeue when 0<count<full: both fire and count is unchanged.
  - Reset mid-operation: count and both pointers go to 0 asynchronously. All buffered responses are discarded. Array contents are not reset but are unobservable.
- Entry order is strict FIFO. The security tag always travels with its own message.

## Timing
- Reset values: net_resp_rdy=1, acc_resp_val=0, acc_resp_msg=0, acc_resp_sec=0, num_free=p_num_entries.
- Latency, non-bypass: a response enqueued at edge N appears on acc_resp_* after edge N (visible in cycle N+1).
- Throughput: 1 response/cycle sustained while 0<count<full.
- acc_resp_val is never withdrawn, and acc_resp_msg/acc_resp_sec never change, until a dequeue fires or reset asserts.

## Configuration
- PLAB5_PROC_RESP_SEC_BUF_BYPASS_EN defined:
  - When count==0, acc_resp_val = net_resp_val.
  - acc_resp_msg = net_resp_msg and acc_resp_sec = net_resp_sec, combinationally.
  - If acc_resp_rdy is also 1, the response passes through in the same cycle without being written and count stays 0. Otherwise it is enqueued normally.
  - Latency is 0 cycles when empty.
- Not defined: no combinational path from net_resp_* to acc_resp_*. Minimum latency is 1 cycle.

## Test plan
- Reset release, no traffic -> net_resp_rdy=1, acc_resp_val=0, acc_resp_sec=0, num_free=2.
- Enqueue msg A (data 0x11) with sec=1, then msg B (data 0x22) with sec=0, acc_resp_rdy=0 -> num_free=0 and net_resp_rdy=0. Raising acc_resp_rdy then yields A/sec=1, then B/sec=0, and num_free returns to 2.
- Full buffer, net_resp_val=1 and acc_resp_rdy=1 in the same cycle -> only the dequeue fires. The new message enters one cycle later and count stays 2 → 1 → 2.
- Eight back-to-back enqueues with acc_resp_rdy=1 throughout, alternating sec 0/1 -> eight outputs in order with matching sec bits, pointers wrap, and there are no bubbles after the first.
- Assert reset while count=2 -> acc_resp_val=0, num_free=2 and acc_resp_sec=0 immediately, without waiting for a clock edge.
- With BYPASS_EN, empty buffer, net_resp_val=1, sec=1, acc_resp_rdy=1 -> same-cycle acc_resp_val=1, acc_resp_sec=1, num_free stays 2. Without BYPASS_EN -> acc_resp_val rises only in the next cycle.
